// File: rtl/opb_register_bank_pkg.sv
`default_nettype none
//==============================================================================
// Module      : opb_register_bank_pkg
// Description : Shared definitions for the OPB register bank: control FSM
//               state encoding, register byte count and the helpers that map
//               between OPB big-endian bit numbering ([0:31], bit 0 = MSB)
//               and the little-endian numbering ([31:0]) used on the user
//               side.
// Revision    : 1.0 - initial release
//==============================================================================
package opb_register_bank_pkg;

    localparam int REG_BYTES = 4;
    localparam int REG_BITS  = 8 * REG_BYTES;

    // Two-state control FSM: IDLE waits for a hit, ACK is the single
    // acknowledge cycle of a transfer.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    // OPB bit k lands on user bit 31-k.  With the OPB word declared [0:31]
    // this keeps the numeric value of the word while renumbering the bits.
    function automatic logic [REG_BITS-1:0] opb_to_user(input logic [0:REG_BITS-1] opb_word);
        logic [REG_BITS-1:0] res;
        res = '0;
        for (int k = 0; k < REG_BITS; k++) begin
            res[REG_BITS-1-k] = opb_word[k];
        end
        return res;
    endfunction

    // Inverse of opb_to_user, used on the read-data path.
    function automatic logic [0:REG_BITS-1] user_to_opb(input logic [REG_BITS-1:0] user_word);
        logic [0:REG_BITS-1] res;
        res = '0;
        for (int k = 0; k < REG_BITS; k++) begin
            res[k] = user_word[REG_BITS-1-k];
        end
        return res;
    endfunction

    // OPB BE[j] covers DBus[8j:8j+7], i.e. user byte lane REG_BYTES-1-j.
    function automatic logic [REG_BYTES-1:0] opb_be_to_user(input logic [0:REG_BYTES-1] opb_be);
        logic [REG_BYTES-1:0] res;
        res = '0;
        for (int j = 0; j < REG_BYTES; j++) begin
            res[REG_BYTES-1-j] = opb_be[j];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/opb_register_bank_if.sv
`default_nettype none
//==============================================================================
// Module      : opb_register_bank_if
// Description : OPB slave-side bus bundle.
//               master : drives OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW,
//                        OPB_select, OPB_seqAddr; receives Sl_* responses.
//               slave  : the mirror image.
// Revision    : 1.0 - initial release
//==============================================================================
interface opb_register_bank_if #(
    parameter int C_OPB_AWIDTH = 32,
    parameter int C_OPB_DWIDTH = 32
) ();

    logic [0:C_OPB_AWIDTH-1]   OPB_ABus;
    logic [0:C_OPB_DWIDTH/8-1] OPB_BE;
    logic [0:C_OPB_DWIDTH-1]   OPB_DBus;
    logic                      OPB_RNW;
    logic                      OPB_select;
    logic                      OPB_seqAddr;

    logic [0:C_OPB_DWIDTH-1]   Sl_DBus;
    logic                      Sl_xferAck;
    logic                      Sl_errAck;
    logic                      Sl_retry;
    logic                      Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

endinterface
`default_nettype wire

// File: rtl/opb_register_bank_reg.sv
`default_nettype none
//==============================================================================
// Module      : opb_register_bank_reg
// Description : One 32-bit byte-enabled register with a one-cycle write
//               strobe that follows the write edge.
// Ports       : clk       - clock
//               rst_n     - asynchronous active-low reset
//               wr_en     - write this cycle (single-cycle qualifier)
//               be        - user-order byte enables, be[b] -> q[8b+7:8b]
//               wdata     - user-order write data
//               q         - register contents
//               wr_pulse  - high for the cycle after an accepted write
// Revision    : 1.0 - initial release
//==============================================================================
module opb_register_bank_reg
    import opb_register_bank_pkg::*;
#(
    parameter logic [REG_BITS-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [REG_BYTES-1:0] be,
    input  logic [REG_BITS-1:0]  wdata,
    output logic [REG_BITS-1:0]  q,
    output logic                 wr_pulse
);

    logic [REG_BITS-1:0] r_q;
    logic                r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= RESET_VALUE;
            r_pulse <= 1'b0;
        end else begin
            // The strobe fires even with all byte enables low.
            r_pulse <= wr_en;
            if (wr_en) begin
                for (int b = 0; b < REG_BYTES; b++) begin
                    if (be[b]) begin
                        r_q[8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign q        = r_q;
    assign wr_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/opb_register_bank.sv
`default_nettype none
//==============================================================================
// Module      : opb_register_bank
// Description : OPB slave exposing C_NUM_REGS 32-bit registers to user logic.
//               Each transfer is accepted on the edge where a hit is seen in
//               IDLE and acknowledged in the following (ACK) cycle.
// Ports       : OPB_Clk        - clock
//               OPB_Rst_n      - asynchronous active-low reset
//               opb            - OPB slave bus bundle
//               user_data_out  - register i on [32i+31:32i] (0 if read-only)
//               user_data_in   - source of read-only registers
//               user_wr_pulse  - one-cycle strobe per written register
// Revision    : 1.0 - initial release
//==============================================================================
module opb_register_bank
    import opb_register_bank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h01000C00,
    parameter logic [31:0] C_HIGHADDR    = 32'h01000CFF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_REGS    = 4,
    parameter logic [15:0] C_RO_MASK     = 16'h0000,
    parameter logic [31:0] C_RESET_VALUE = 32'h0
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    opb_register_bank_if.slave        opb,
    output logic [32*C_NUM_REGS-1:0]  user_data_out,
    input  logic [32*C_NUM_REGS-1:0]  user_data_in,
    output logic [C_NUM_REGS-1:0]     user_wr_pulse
);

    localparam int AW    = C_OPB_AWIDTH;
    localparam int IDX_W = AW - 2;
    localparam logic [AW-1:0] BASE_ADDR = AW'(C_BASEADDR);
    localparam logic [AW-1:0] HIGH_ADDR = AW'(C_HIGHADDR);

    //--------------------------------------------------------------------------
    // Elaboration-time parameter checks
    //--------------------------------------------------------------------------
    if (C_OPB_DWIDTH != 32) begin : g_chk_dwidth
        $error("opb_register_bank: C_OPB_DWIDTH must be 32");
    end
    if ((C_NUM_REGS < 1) || (C_NUM_REGS > 16)) begin : g_chk_num_regs
        $error("opb_register_bank: C_NUM_REGS must be in 1..16");
    end

    //--------------------------------------------------------------------------
    // Address decode
    //--------------------------------------------------------------------------
    logic [AW-1:0]         w_addr;
    logic [AW-1:0]         w_offset;
    logic [IDX_W-1:0]      w_index;
    logic                  w_hit;
    logic                  w_idx_valid;
    logic [C_NUM_REGS-1:0] w_sel;
    logic                  w_ro_hit;

    // Positional copy: OPB bit 0 is the MSB, so the numeric address is kept.
    assign w_addr      = opb.OPB_ABus;
    assign w_hit       = opb.OPB_select && (w_addr >= BASE_ADDR) && (w_addr <= HIGH_ADDR);
    assign w_offset    = w_addr - BASE_ADDR;
    assign w_index     = w_offset[AW-1:2];
    assign w_idx_valid = (w_index < IDX_W'(C_NUM_REGS));
    assign w_ro_hit    = |(w_sel & C_RO_MASK[C_NUM_REGS-1:0]);

    //--------------------------------------------------------------------------
    // Control FSM
    //--------------------------------------------------------------------------
    state_t r_state;
    state_t w_next_state;
    logic   w_start;
    logic   w_is_write;

    // A hit seen while in ACK is ignored here and picked up again in IDLE.
    assign w_start    = (r_state == ST_IDLE) && w_hit;
    assign w_is_write = !opb.OPB_RNW;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_hit) w_next_state = ST_ACK;
            ST_ACK:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Register array
    //--------------------------------------------------------------------------
    logic [REG_BITS-1:0]  w_wdata;
    logic [REG_BYTES-1:0] w_be;
    logic [REG_BITS-1:0]  w_reg_val [C_NUM_REGS];

    assign w_wdata = opb_to_user(opb.OPB_DBus);
    assign w_be    = opb_be_to_user(opb.OPB_BE);

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_regs
        assign w_sel[i] = w_idx_valid && (w_index == IDX_W'(i));

        if (C_RO_MASK[i]) begin : g_ro
            // Read-only: contents come from user logic, nothing is stored.
            assign w_reg_val[i]                = user_data_in[32*i +: 32];
            assign user_data_out[32*i +: 32]   = '0;
            assign user_wr_pulse[i]            = 1'b0;
        end else begin : g_rw
            logic                w_wr_en;
            logic [REG_BITS-1:0] w_q;

            assign w_wr_en = w_start && w_is_write && w_sel[i];

            opb_register_bank_reg #(
                .RESET_VALUE (C_RESET_VALUE)
            ) u_reg (
                .clk      (OPB_Clk),
                .rst_n    (OPB_Rst_n),
                .wr_en    (w_wr_en),
                .be       (w_be),
                .wdata    (w_wdata),
                .q        (w_q),
                .wr_pulse (user_wr_pulse[i])
            );

            assign w_reg_val[i]              = w_q;
            assign user_data_out[32*i +: 32] = w_q;
        end
    end

    // One-hot select, so OR-ing the gated values forms the read mux; an
    // index past C_NUM_REGS selects nothing and reads back zero.
    logic [REG_BITS-1:0] w_rd_word;

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (w_sel[i]) begin
                w_rd_word = w_rd_word | w_reg_val[i];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Response capture on the accepting edge
    //--------------------------------------------------------------------------
    logic [REG_BITS-1:0] r_rdata;
    logic                r_err;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_start) begin
            r_rdata <= opb.OPB_RNW ? w_rd_word : '0;
            r_err   <= w_is_write && w_ro_hit;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs: gated by the ACK state so that an asynchronous reset drops
    // every acknowledge and the data bus in the same instant.
    //--------------------------------------------------------------------------
    always_comb begin
        opb.Sl_xferAck = 1'b0;
        opb.Sl_errAck  = 1'b0;
        opb.Sl_DBus    = '0;
        if (r_state == ST_ACK) begin
            opb.Sl_xferAck = !r_err;
            opb.Sl_errAck  = r_err;
            opb.Sl_DBus    = user_to_opb(r_rdata);
        end
    end

    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    // Address LSBs, the sequential hint and the user_data_in slices of
    // writable registers carry no function.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, w_offset[1:0], opb.OPB_seqAddr, user_data_in};

endmodule
`default_nettype wire

// File: tb/tb_opb_register_bank.sv
`default_nettype none
//==============================================================================
// Module      : tb_opb_register_bank
// Description : Self-checking bench for opb_register_bank: directed scenarios
//               followed by random transfers against an array-based model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_opb_register_bank;

    localparam int          NREGS = 4;
    localparam logic [31:0] BASE  = 32'h01000C00;
    localparam logic [31:0] HIGH  = 32'h01000CFF;
    localparam logic [15:0] RO    = 16'h0008;
    localparam logic [31:0] RSTV  = 32'h5A5A00FF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [32*NREGS-1:0] udo;
    logic [32*NREGS-1:0] udi;
    logic [NREGS-1:0]    pulse;

    int checks   = 0;
    int failures = 0;

    // Model: register contents as seen on user_data_out for writable indices.
    logic [31:0] mdl [NREGS];

    opb_register_bank_if #(.C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32)) bus ();

    opb_register_bank #(
        .C_BASEADDR    (BASE),
        .C_HIGHADDR    (HIGH),
        .C_OPB_AWIDTH  (32),
        .C_OPB_DWIDTH  (32),
        .C_NUM_REGS    (NREGS),
        .C_RO_MASK     (RO),
        .C_RESET_VALUE (RSTV)
    ) dut (
        .OPB_Clk       (clk),
        .OPB_Rst_n     (rst_n),
        .opb           (bus),
        .user_data_out (udo),
        .user_data_in  (udi),
        .user_wr_pulse (pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_user(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            chk(tag, udo[32*i +: 32], RO[i] ? 32'h0 : mdl[i]);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk(tag, {29'h0, bus.Sl_xferAck, bus.Sl_errAck, 1'b0}, 32'h0);
        chk(tag, bus.Sl_DBus, 32'h0);
        chk(tag, {28'h0, pulse}, 32'h0);
    endtask

    // One transfer: drive at cycle start, check the ACK cycle, then the
    // following idle cycle. Called #1 after a rising edge in IDLE.
    task automatic xfer(input logic rnw, input logic [31:0] addr,
                        input logic [0:3] be, input logic [31:0] data);
        logic        hit;
        int          idx;
        logic        exp_x, exp_e;
        logic [31:0] exp_d;
        logic [NREGS-1:0] exp_p;
        hit   = (addr >= BASE) && (addr <= HIGH);
        idx   = int'((addr - BASE) >> 2);
        exp_x = 1'b0; exp_e = 1'b0; exp_d = 32'h0; exp_p = '0;
        if (hit) begin
            if (idx >= NREGS) begin
                exp_x = 1'b1;
            end else if (RO[idx]) begin
                if (rnw) begin
                    exp_x = 1'b1;
                    exp_d = udi[32*idx +: 32];
                end else begin
                    exp_e = 1'b1;
                end
            end else begin
                exp_x = 1'b1;
                if (rnw) begin
                    exp_d = mdl[idx];
                end else begin
                    exp_p[idx] = 1'b1;
                    for (int j = 0; j < 4; j++) begin
                        if (be[j]) mdl[idx][31-8*j -: 8] = data[31-8*j -: 8];
                    end
                end
            end
        end
        bus.OPB_ABus   = addr;
        bus.OPB_BE     = be;
        bus.OPB_DBus   = data;
        bus.OPB_RNW    = rnw;
        bus.OPB_select = 1'b1;
        @(posedge clk); #1;
        chk("xferAck", {31'h0, bus.Sl_xferAck}, {31'h0, exp_x});
        chk("errAck",  {31'h0, bus.Sl_errAck},  {31'h0, exp_e});
        chk("acks_exclusive", {31'h0, bus.Sl_xferAck & bus.Sl_errAck}, 32'h0);
        chk("rdata",   bus.Sl_DBus, exp_d);
        chk("wr_pulse", {28'h0, pulse}, {28'h0, exp_p});
        check_user("user_data_out");
        bus.OPB_select = 1'b0;
        @(posedge clk); #1;
        check_quiet("post_ack");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.OPB_ABus    = '0;
        bus.OPB_BE      = '0;
        bus.OPB_DBus    = '0;
        bus.OPB_RNW     = 1'b1;
        bus.OPB_select  = 1'b0;
        bus.OPB_seqAddr = 1'b0;
        udi = {32'hCAFEF00D, $urandom, $urandom, $urandom};
        for (int i = 0; i < NREGS; i++) mdl[i] = RSTV;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        check_user("reset_regs");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-word write then read-back
        xfer(1'b0, 32'h01000C04, 4'b1111, 32'h12345678);
        xfer(1'b1, 32'h01000C04, 4'b1111, 32'h0);

        // Single-lane clear: BE[1] covers DBus[8:15]
        xfer(1'b0, 32'h01000C00, 4'b1111, 32'hFFFFFFFF);
        xfer(1'b0, 32'h01000C00, 4'b0100, 32'h00000000);
        chk("lane_clear", udo[31:0], 32'hFF00FFFF);
        xfer(1'b1, 32'h01000C00, 4'b0000, 32'h0);

        // Write with no byte enables still pulses, changes nothing
        xfer(1'b0, 32'h01000C08, 4'b0000, 32'hDEADBEEF);

        // Read-only register
        xfer(1'b1, 32'h01000C0C, 4'b1111, 32'h0);
        xfer(1'b0, 32'h01000C0C, 4'b1111, 32'h11111111);

        // Unimplemented index inside the range, then outside the range
        xfer(1'b1, 32'h01000C40, 4'b1111, 32'h0);
        xfer(1'b0, 32'h01000C40, 4'b1111, 32'h55555555);
        xfer(1'b1, 32'h01000D00, 4'b1111, 32'h0);
        xfer(1'b1, 32'h01000BFC, 4'b1111, 32'h0);

        // select held for six cycles: acknowledges on cycles 2, 4, 6
        bus.OPB_ABus   = 32'h01000C00;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_select = 1'b1;
        chk("burst_c1", {31'h0, bus.Sl_xferAck}, 32'h0);
        for (int c = 2; c <= 6; c++) begin
            @(posedge clk); #1;
            chk("burst_ack", {31'h0, bus.Sl_xferAck}, (c % 2 == 0) ? 32'h1 : 32'h0);
        end
        bus.OPB_select = 1'b0;
        @(posedge clk); #1;
        check_quiet("burst_end");

        // Reset asserted during ACK of a write
        bus.OPB_ABus   = 32'h01000C08;
        bus.OPB_BE     = 4'b1111;
        bus.OPB_DBus   = 32'hA1B2C3D4;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_select = 1'b1;
        @(posedge clk); #1;
        chk("rst_pre_ack", {31'h0, bus.Sl_xferAck}, 32'h1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NREGS; i++) mdl[i] = RSTV;
        check_quiet("rst_during_ack");
        check_user("rst_regs");
        bus.OPB_select = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NREGS; i++) xfer(1'b1, BASE + 32'(4*i), 4'b1111, 32'h0);

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            int          kind;
            kind = $urandom_range(0, 9);
            if (kind <= 6)      a = BASE + 32'($urandom_range(0, NREGS-1) * 4) + 32'($urandom_range(0, 3));
            else if (kind == 7) a = BASE + 32'($urandom_range(NREGS, 63) * 4);
            else if (kind == 8) a = HIGH + 32'($urandom_range(1, 256));
            else                a = BASE - 32'($urandom_range(1, 256));
            udi = {$urandom, $urandom, $urandom, $urandom};
            xfer(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
